// File: rtl/pm_pkg.sv
// Shared constants and event record layout for the pattern-match event queue.
package pm_pkg;
  localparam int PM_DATA_SIZE  = 32;
  localparam int PM_IDX_W      = 16;
  localparam int PM_DROP_CNT_W = 16;

  typedef struct packed {
    logic [PM_IDX_W-1:0]     idx;
    logic [PM_DATA_SIZE-1:0] data;
  } pm_evt_t;
endpackage

// File: rtl/pm_evt_fifo.sv
// Generic first-word-fall-through synchronous FIFO; occupancy tracked by an
// explicit level counter so full and empty never alias on pointer equality.
module pm_evt_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign rd_en = pop && !empty && !clr;
  assign wr_en = push && !clr && (!full || rd_en);

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Head reads as zero when empty so stale storage never leaks out.
  assign dout = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/pattern_match_event_q.sv
// Captures {word index, data} for every matched word into an FWFT event FIFO.
// Optional PM_EVT_DROP_CNT_EN adds a saturating dropped-event counter.
module pattern_match_event_q
  import pm_pkg::*;
#(
  parameter int DATA_SIZE = PM_DATA_SIZE,
  parameter int IDX_W     = PM_IDX_W,
  parameter int DEPTH     = 8,
  parameter int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 match_in,
  input  logic                 clr,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [DATA_SIZE-1:0] evt_data,
  output logic [IDX_W-1:0]     evt_idx,
  output logic [LVL_W-1:0]     level,
  output logic                 overflow
`ifdef PM_EVT_DROP_CNT_EN
  , output logic [PM_DROP_CNT_W-1:0] drop_cnt
`endif
);
  localparam int EW = IDX_W + DATA_SIZE;

  logic [IDX_W-1:0] idx;
  logic [EW-1:0]    head;
  logic             push, pop, full, empty, drop;

  assign push = en && match_in;
  assign pop  = evt_valid && evt_ready;
  assign drop = push && full && !pop && !clr;

  pm_evt_fifo #(.WIDTH(EW), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   ({idx, data_in}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign evt_valid           = !empty;
  assign {evt_idx, evt_data} = head;

  // Index is pre-increment at capture, so the first qualified word is 0.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      idx      <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      if (en)   idx      <= idx + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef PM_EVT_DROP_CNT_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                    drop_cnt <= '0;
    else if (clr)                 drop_cnt <= '0;
    else if (drop && ~&drop_cnt)  drop_cnt <= drop_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_pattern_match_event_q.sv
// Directed bench: a queue-based event model checks two instances (16-bit and
// 4-bit index) every cycle, plus hand-computed literal checkpoints.
module tb_pattern_match_event_q;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstb, en, match_in, clr, evt_ready;
  logic [31:0] data_in;

  logic        va, vb, ova, ovb;
  logic [31:0] da, db;
  logic [15:0] ia;
  logic [3:0]  ib;
  logic [3:0]  la, lb;
`ifdef PM_EVT_DROP_CNT_EN
  logic [15:0] dca, dcb;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  pattern_match_event_q #(.DATA_SIZE(32), .IDX_W(16), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rstb(rstb), .en(en), .data_in(data_in), .match_in(match_in),
    .clr(clr), .evt_valid(va), .evt_ready(evt_ready), .evt_data(da),
    .evt_idx(ia), .level(la), .overflow(ova)
`ifdef PM_EVT_DROP_CNT_EN
    , .drop_cnt(dca)
`endif
  );

  pattern_match_event_q #(.DATA_SIZE(32), .IDX_W(4), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rstb(rstb), .en(en), .data_in(data_in), .match_in(match_in),
    .clr(clr), .evt_valid(vb), .evt_ready(evt_ready), .evt_data(db),
    .evt_idx(ib), .level(lb), .overflow(ovb)
`ifdef PM_EVT_DROP_CNT_EN
    , .drop_cnt(dcb)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the event queue as plain records; index is an unbounded count.
  typedef struct { int unsigned idx; logic [31:0] data; } evt_t;
  evt_t        q[$];
  int unsigned m_idx;
  bit          m_ovf;
  int unsigned m_drop;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      q.delete(); m_idx = 0; m_ovf = 0; m_drop = 0;
    end else begin
      bit pop_ok;
      pop_ok = (q.size() > 0) && evt_ready;
      if (clr) begin
        q.delete(); m_idx = 0; m_ovf = 0; m_drop = 0;
      end else begin
        if (pop_ok) void'(q.pop_front());
        if (en && match_in) begin
          if (q.size() < DEPTH) q.push_back('{m_idx, data_in});
          else begin
            m_ovf = 1;
            if (m_drop < 32'hFFFF) m_drop++;
          end
        end
        if (en) m_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (rstb) begin
      logic [31:0] ed;
      int unsigned ei;
      ed = (q.size() > 0) ? q[0].data : 32'h0;
      ei = (q.size() > 0) ? q[0].idx  : 0;
      chk("a.valid", 64'(va), 64'(q.size() > 0));
      chk("a.data",  64'(da), 64'(ed));
      chk("a.idx",   64'(ia), 64'(ei % 65536));
      chk("a.level", 64'(la), 64'(q.size()));
      chk("a.ovf",   64'(ova), 64'(m_ovf));
      chk("b.valid", 64'(vb), 64'(q.size() > 0));
      chk("b.data",  64'(db), 64'(ed));
      chk("b.idx",   64'(ib), 64'(ei % 16));
      chk("b.level", 64'(lb), 64'(q.size()));
      chk("b.ovf",   64'(ovb), 64'(m_ovf));
`ifdef PM_EVT_DROP_CNT_EN
      chk("a.drop_cnt", 64'(dca), 64'(m_drop));
      chk("b.drop_cnt", 64'(dcb), 64'(m_drop));
`endif
    end
  end

  task automatic cyc(input logic e, input logic m, input logic [31:0] d,
                     input logic r, input logic c);
    en = e; match_in = m; data_in = d; evt_ready = r; clr = c;
    @(posedge clk); #1;
  endtask

  initial begin
    rstb = 1'b0; en = 0; match_in = 0; data_in = 0; evt_ready = 0; clr = 0;
    #2;
    chk("rst.valid", 64'(va), 64'd0);
    chk("rst.level", 64'(la), 64'd0);
    chk("rst.ovf",   64'(ova), 64'd0);
    chk("rst.data",  64'(da), 64'd0);
    chk("rst.idx",   64'(ia), 64'd0);
    #10 rstb = 1'b1;

    // First event: 4th qualified word carries index 3.
    repeat (3) cyc(1, 0, 32'h0, 0, 0);
    cyc(1, 1, 32'hDEADBEEF, 0, 0);
    chk("t1.valid", 64'(va), 64'd1);
    chk("t1.idx",   64'(ia), 64'd3);
    chk("t1.data",  64'(da), 64'hDEADBEEF);
    chk("t1.level", 64'(la), 64'd1);
    cyc(1, 0, 32'h0, 0, 0);
    cyc(0, 0, 32'h0, 1, 0);
    chk("t1.drained", 64'(la), 64'd0);

    // Nine pushes into eight slots: last one dropped.
    for (int i = 0; i < 9; i++) cyc(1, 1, 32'h100 + i, 0, 0);
    chk("t2.level", 64'(la), 64'd8);
    chk("t2.ovf",   64'(ova), 64'd1);
    chk("t2.head_idx", 64'(ia), 64'd5);
`ifdef PM_EVT_DROP_CNT_EN
    chk("t2.drop_cnt", 64'(dca), 64'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      chk("t2.order", 64'(da), 64'(32'h100 + i));
      cyc(0, 0, 32'h0, 1, 0);
    end
    chk("t2.empty", 64'(va), 64'd0);
    chk("t2.ovf_sticky", 64'(ova), 64'd1);

    // Full with simultaneous push and pop: accepted, no overflow.
    cyc(0, 0, 32'h0, 0, 1);
    chk("t3.clr_ovf", 64'(ova), 64'd0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 32'h200 + i, 0, 0);
    cyc(1, 1, 32'h2FF, 1, 0);
    chk("t3.level", 64'(la), 64'd8);
    chk("t3.ovf",   64'(ova), 64'd0);
    for (int i = 1; i < 8; i++) begin
      chk("t3.order", 64'(da), 64'(32'h200 + i));
      cyc(0, 0, 32'h0, 1, 0);
    end
    chk("t3.last", 64'(da), 64'h2FF);
    cyc(0, 0, 32'h0, 1, 0);

    // Index wrap on the 4-bit instance; en=0 words interleaved.
    cyc(0, 0, 32'h0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 32'h0, 0, 0);
      cyc(0, 1, 32'h0, 0, 0);
    end
    cyc(1, 1, 32'hABCD, 0, 0);
    chk("t4.b_idx", 64'(ib), 64'd0);
    chk("t4.a_idx", 64'(ia), 64'd16);
    chk("t4.data",  64'(db), 64'hABCD);
    cyc(0, 0, 32'h0, 1, 0);

    // clr beats a same-cycle push at level 5 with overflow set.
    for (int i = 0; i < 9; i++) cyc(1, 1, 32'h300 + i, 0, 0);
    repeat (3) cyc(0, 0, 32'h0, 1, 0);
    chk("t5.level", 64'(la), 64'd5);
    chk("t5.ovf",   64'(ova), 64'd1);
    cyc(1, 1, 32'h3FF, 0, 1);
    chk("t5.clr_level", 64'(la), 64'd0);
    chk("t5.clr_valid", 64'(va), 64'd0);
    chk("t5.clr_ovf",   64'(ova), 64'd0);
    cyc(1, 1, 32'h55, 0, 0);
    chk("t5.idx0", 64'(ia), 64'd0);
    chk("t5.data", 64'(da), 64'h55);
    cyc(0, 0, 32'h0, 1, 0);

    // Asynchronous reset mid-drain with three entries waiting.
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'h400 + i, 0, 0);
    cyc(0, 0, 32'h0, 1, 0);
    chk("t6.level", 64'(la), 64'd3);
    #2 rstb = 1'b0;
    #1;
    chk("t6.async_valid", 64'(va), 64'd0);
    chk("t6.async_level", 64'(la), 64'd0);
    chk("t6.async_b_lvl", 64'(lb), 64'd0);
    #10 rstb = 1'b1;
    cyc(1, 1, 32'h77, 0, 0);
    chk("t6.fresh_idx",   64'(ia), 64'd0);
    chk("t6.fresh_level", 64'(la), 64'd1);
    chk("t6.fresh_data",  64'(da), 64'h77);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
